// File: rtl/seq_add64.sv
// Multi-cycle WORDS*16-bit adder/subtractor that feeds one 16-bit slice per cycle through cla16,
// chaining the slice carry through a register. Also holds the cla16 slice adder it instantiates.

module seq_add64 #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  carryIn,
  input  logic                  sub,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [16*WORDS-1:0]   sum,
  output logic                  carryOut,
  output logic                  overflow,
  output logic                  zero
);

  localparam int unsigned W  = 16 * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e r_state, w_state_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_carry_out;
  logic          r_overflow;
  logic          r_zero;

  logic [15:0]   w_slice_a;
  logic [15:0]   w_slice_b;
  logic [15:0]   w_slice_sum;
  logic          w_slice_co;
  logic          w_prop;
  logic          w_gene;
  logic          w_unused_pg;
  logic          w_last;
  logic [W-1:0]  w_final;

  assign w_slice_a   = r_a[{r_idx, 4'b0000} +: 16];
  assign w_slice_b   = r_b[{r_idx, 4'b0000} +: 16];
  assign w_last      = (r_idx == IW'(WORDS - 1));
  assign w_unused_pg = w_prop ^ w_gene;

  cla16 u_cla16 (
    .a           (w_slice_a),
    .b           (w_slice_b),
    .carryInput  (r_carry),
    .sum         (w_slice_sum),
    .carryOutput (w_slice_co),
    .prop        (w_prop),
    .gene        (w_gene)
  );

  // Complete result as it will look after the final slice is written.
  always_comb begin
    w_final            = r_sum;
    w_final[W-1 -: 16] = w_slice_sum;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (inValid)  w_state_next = StRun;
      StRun:   if (w_last)   w_state_next = StDone;
      StDone:  if (outReady) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (inValid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | carryIn;
            r_idx   <= '0;
          end
        end
        StRun: begin
          r_sum[{r_idx, 4'b0000} +: 16] <= w_slice_sum;
          r_carry                       <= w_slice_co;
          r_idx                         <= r_idx + 1'b1;
          if (w_last) begin
            r_carry_out <= w_slice_co;
            r_overflow  <= (r_a[W-1] == r_b[W-1]) && (w_slice_sum[15] != r_a[W-1]);
            r_zero      <= (w_final == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign inReady  = (r_state == StIdle);
  assign outValid = (r_state == StDone);
  assign sum      = r_sum;
  assign carryOut = r_carry_out;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule

// 16-bit two-level carry-lookahead adder: four 4-bit groups with group propagate/generate.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carryInput,
  output logic [15:0] sum,
  output logic        carryOutput,
  output logic        prop,
  output logic        gene
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [3:0]  w_gp;
  logic [3:0]  w_gg;
  logic [4:0]  w_gc;
  logic [16:0] w_c;

  always_comb begin
    w_p = a ^ b;
    w_g = a & b;
    for (int k = 0; k < 4; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

  always_comb begin
    w_gc[0] = carryInput;
    w_gc[1] = w_gg[0] | (w_gp[0] & carryInput);
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & carryInput);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & carryInput);
    gene    = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
    prop    = &w_gp;
    w_gc[4] = gene | (prop & carryInput);
    carryOutput = w_gc[4];
  end

  // Within each group the bit carries ripple from the looked-ahead group carry.
  always_comb begin
    w_c = '0;
    for (int k = 0; k < 4; k++) begin
      w_c[4*k] = w_gc[k];
      for (int i = 0; i < 4; i++) begin
        w_c[4*k+i+1] = w_g[4*k+i] | (w_p[4*k+i] & w_c[4*k+i]);
      end
    end
    sum = w_p ^ w_c[15:0];
  end

endmodule
